// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequencer between the pipeline and the shared multiplier/divider.
// Accepts one request at a time, latches operands and tag, pulses the selected
// unit's start, waits for its ready (or a timeout) and returns a one-cycle result.
// Optional feature: define MULTDIV_DIVZERO_EARLY_EN to complete a divide by zero
// straight from IDLE without starting the divider.
// TIMEOUT must be at least 34 so the 32-iteration divider can finish in time.
module multdiv_ctrl #(
   parameter int TAG_W   = 5,
   parameter int TIMEOUT = 40
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_mult,
   input  logic             req_div,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             busy,
   output logic             res_valid,
   output logic [31:0]      res_data,
   output logic [TAG_W-1:0] res_tag,
   output logic             res_exception,
   output logic [31:0]      unit_a,
   output logic [31:0]      unit_b,
   output logic             mult_start,
   output logic             div_start,
   input  logic             mult_ready,
   input  logic [31:0]      mult_result,
   input  logic             mult_exception,
   input  logic             div_ready,
   input  logic [31:0]      div_quotient,
   input  logic             div_exception
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MULT_RUN = 2'd1,
      DIV_RUN  = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [TAG_W-1:0]   tag_q;

   logic               in_run;
   logic               accept;
   logic               early_zero;
   logic               sel_ready;
   logic [31:0]        sel_result;
   logic               sel_exc;
   logic               unit_done;
   logic               timeout_hit;

   assign in_run      = (state == MULT_RUN) || (state == DIV_RUN);
   assign accept      = (state == IDLE) && !flush && (req_mult || req_div);
   assign sel_ready   = (state == MULT_RUN) ? mult_ready     : div_ready;
   assign sel_result  = (state == MULT_RUN) ? mult_result    : div_quotient;
   assign sel_exc     = (state == MULT_RUN) ? mult_exception : div_exception;
   // the unit's own counter is stale in the first RUN cycle, so ready only counts afterwards
   assign unit_done   = in_run && (cnt != '0) && sel_ready;
   assign timeout_hit = in_run && (cnt == CNT_LAST);

`ifdef MULTDIV_DIVZERO_EARLY_EN
   // a lone divide by zero is answered immediately; multiply wins when both are requested
   assign early_zero  = req_div && !req_mult && (in_b == '0);
`else
   assign early_zero  = 1'b0;
`endif

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; flush always returns to IDLE and beats a simultaneous request
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (!flush) begin
               if (req_mult) begin
                  state_nxt = MULT_RUN;
               end else if (req_div) begin
                  state_nxt = early_zero ? DONE : DIV_RUN;
               end
            end
         end
         MULT_RUN, DIV_RUN: begin
            if (flush) begin
               state_nxt = IDLE;
            end else if (unit_done || timeout_hit) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode from state; flush suppresses a start or result in its own cycle
   always_comb begin
      busy       = (state != IDLE);
      mult_start = (state == MULT_RUN) && (cnt == '0) && !flush;
      div_start  = (state == DIV_RUN)  && (cnt == '0) && !flush;
      res_valid  = (state == DONE) && !flush;
   end

   // Operand/tag latch, RUN cycle counter and result capture
   always_ff @(posedge clock) begin
      if (reset) begin
         unit_a        <= '0;
         unit_b        <= '0;
         tag_q         <= '0;
         cnt           <= '0;
         res_data      <= '0;
         res_tag       <= '0;
         res_exception <= 1'b0;
      end else begin
         // operands stay frozen for the whole operation: the units read them every iteration
         if (accept) begin
            unit_a <= in_a;
            unit_b <= in_b;
            tag_q  <= in_tag;
            cnt    <= '0;
         end else if (in_run) begin
            cnt <= cnt + 1'b1;
         end

         if (accept && early_zero) begin
            res_data      <= '0;
            res_exception <= 1'b1;
            res_tag       <= in_tag;
         end else if (in_run && !flush) begin
            if (unit_done) begin
               res_data      <= sel_result;
               res_exception <= sel_exc;
               res_tag       <= tag_q;
            end else if (timeout_hit) begin
               res_data      <= '0;
               res_exception <= 1'b1;
               res_tag       <= tag_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Testbench for multdiv_ctrl: behavioural multiplier/divider stubs plus a
// spec-level model of latency, result and exception for every operation.
module tb_multdiv_ctrl;

   localparam int TAG_W = 5;

   logic             clock = 1'b0;
   logic             reset;
   logic             req_mult;
   logic             req_div;
   logic [31:0]      in_a;
   logic [31:0]      in_b;
   logic [TAG_W-1:0] in_tag;
   logic             flush;
   logic             busy;
   logic             res_valid;
   logic [31:0]      res_data;
   logic [TAG_W-1:0] res_tag;
   logic             res_exception;
   logic [31:0]      unit_a;
   logic [31:0]      unit_b;
   logic             mult_start;
   logic             div_start;
   logic             mult_ready;
   logic [31:0]      mult_result;
   logic             mult_exception;
   logic             div_ready;
   logic [31:0]      div_quotient;
   logic             div_exception;

   int tests_run    = 0;
   int tests_failed = 0;

   // unit stubs: ready idles high, drops on start, and returns after the unit latency
   int  mlat     = 4;
   bit  stuck    = 1'b0;
   int  mult_cnt = 0;
   int  div_cnt  = 0;
   logic [63:0] prod;

   always @(posedge clock) begin
      if (mult_start) mult_cnt <= mlat - 1;
      else if (mult_cnt != 0) mult_cnt <= mult_cnt - 1;
      if (div_start) div_cnt <= 31;
      else if (div_cnt != 0) div_cnt <= div_cnt - 1;
   end

   assign prod           = {32'b0, unit_a} * {32'b0, unit_b};
   assign mult_ready     = !stuck && (mult_cnt == 0);
   assign mult_result    = prod[31:0];
   assign mult_exception = |prod[63:32];
   assign div_ready      = !stuck && (div_cnt == 0);
   assign div_quotient   = (unit_b == 32'd0) ? 32'hFFFF_FFFF : unit_a / unit_b;
   assign div_exception  = (unit_b == 32'd0);

   multdiv_ctrl #(.TAG_W(TAG_W), .TIMEOUT(40)) dut (
      .clock(clock), .reset(reset), .req_mult(req_mult), .req_div(req_div),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
      .busy(busy), .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag),
      .res_exception(res_exception), .unit_a(unit_a), .unit_b(unit_b),
      .mult_start(mult_start), .div_start(div_start),
      .mult_ready(mult_ready), .mult_result(mult_result), .mult_exception(mult_exception),
      .div_ready(div_ready), .div_quotient(div_quotient), .div_exception(div_exception)
   );

   always #5 clock = ~clock;

   // One operation from request to the idle cycle after the result.
   // no_wait: caller is already at the negedge of the request cycle (back-to-back).
   task automatic run_op(input bit rm, input bit rd, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input int lat_m, input bit stk,
                         input bit no_wait, input string name);
      int          exp_lat;
      logic [31:0] exp_data;
      bit          exp_exc;
      int          exp_ms, exp_ds;
      bit          early;
      longint unsigned p;
      int          vcnt, vcyc, ms_cnt, ms_cyc, ds_cnt, ds_cyc;
      logic [31:0] vdata;
      logic [TAG_W-1:0] vtag;
      logic        vexc;
      bit          stable, busy1, busy_after;
      logic [31:0] held;

      early = 1'b0;
`ifdef MULTDIV_DIVZERO_EARLY_EN
      early = !rm && rd && (b == 32'd0);
`endif
      exp_ms = 0;
      exp_ds = 0;
      if (early) begin
         exp_lat = 1; exp_data = 32'd0; exp_exc = 1'b1;
      end else if (rm) begin
         exp_ms = 1;
         p = longint'(a) * longint'(b);
         if (stk) begin exp_lat = 41; exp_data = 32'd0; exp_exc = 1'b1; end
         else begin exp_lat = lat_m + 2; exp_data = p[31:0]; exp_exc = (p[63:32] != 0); end
      end else begin
         exp_ds = 1;
         if (stk) begin exp_lat = 41; exp_data = 32'd0; exp_exc = 1'b1; end
         else begin
            exp_lat  = 34;
            exp_data = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            exp_exc  = (b == 32'd0);
         end
      end

      mlat  = lat_m;
      stuck = stk;
      if (!no_wait) @(negedge clock);
      req_mult = rm; req_div = rd; in_a = a; in_b = b; in_tag = tag;

      vcnt = 0; vcyc = -1; ms_cnt = 0; ms_cyc = -1; ds_cnt = 0; ds_cyc = -1;
      vdata = '0; vtag = '0; vexc = 1'b0; stable = 1'b1; busy1 = 1'b0; busy_after = 1'b1;
      held = '0;
      for (int cyc = 1; cyc <= exp_lat + 1; cyc++) begin
         @(negedge clock);
         if (mult_start) begin ms_cnt++; ms_cyc = cyc; end
         if (div_start)  begin ds_cnt++; ds_cyc = cyc; end
         if (res_valid) begin
            vcnt++; vcyc = cyc; vdata = res_data; vtag = res_tag; vexc = res_exception;
         end
         if (cyc <= exp_lat && (unit_a !== a || unit_b !== b)) stable = 1'b0;
         if (cyc == 1) busy1 = busy;
         if (cyc == exp_lat + 1) begin busy_after = busy; held = res_data; end
         // inputs change after acceptance; a stray request while busy must be ignored
         if (cyc == 1) begin
            req_mult = 1'b0; req_div = 1'b0;
            in_a = $urandom; in_b = $urandom; in_tag = TAG_W'($urandom);
         end
         if (cyc == 5 && exp_lat > 8) req_mult = 1'b1;
         if (cyc == 6) req_mult = 1'b0;
      end
      stuck = 1'b0;

      tests_run++;
      if (vcnt !== 1 || vcyc !== exp_lat) begin
         tests_failed++;
         $display("FAIL %s res_valid: count %0d at cycle %0d, want 1 at cycle %0d", name, vcnt, vcyc, exp_lat);
      end
      tests_run++;
      if (vdata !== exp_data) begin
         tests_failed++;
         $display("FAIL %s res_data: got %h want %h", name, vdata, exp_data);
      end
      tests_run++;
      if (vtag !== tag) begin
         tests_failed++;
         $display("FAIL %s res_tag: got %0d want %0d", name, vtag, tag);
      end
      tests_run++;
      if (vexc !== exp_exc) begin
         tests_failed++;
         $display("FAIL %s res_exception: got %0b want %0b", name, vexc, exp_exc);
      end
      tests_run++;
      if (ms_cnt !== exp_ms || (exp_ms == 1 && ms_cyc !== 1)) begin
         tests_failed++;
         $display("FAIL %s mult_start: %0d pulses last cycle %0d, want %0d in cycle 1", name, ms_cnt, ms_cyc, exp_ms);
      end
      tests_run++;
      if (ds_cnt !== exp_ds || (exp_ds == 1 && ds_cyc !== 1)) begin
         tests_failed++;
         $display("FAIL %s div_start: %0d pulses last cycle %0d, want %0d in cycle 1", name, ds_cnt, ds_cyc, exp_ds);
      end
      tests_run++;
      if (!stable) begin
         tests_failed++;
         $display("FAIL %s operands: unit_a/unit_b changed, want %h/%h held", name, a, b);
      end
      tests_run++;
      if (busy1 !== 1'b1 || busy_after !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s busy: cycle1 %0b after-result %0b, want 1 and 0", name, busy1, busy_after);
      end
      tests_run++;
      if (held !== exp_data) begin
         tests_failed++;
         $display("FAIL %s res_data hold: got %h want %h", name, held, exp_data);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; req_mult = 1'b0; req_div = 1'b0; flush = 1'b0;
      in_a = '0; in_b = '0; in_tag = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         tests_run++;
         if ({busy, res_valid, mult_start, div_start} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_idle cycle %0d: busy/valid/mstart/dstart = %b want 0000", i,
                     {busy, res_valid, mult_start, div_start});
         end
      end
      tests_run++;
      if (res_data !== 32'd0 || res_tag !== '0 || res_exception !== 1'b0 || unit_a !== 32'd0 || unit_b !== 32'd0) begin
         tests_failed++;
         $display("FAIL reset_regs: res_data %h tag %0d exc %0b unit_a %h unit_b %h want all 0",
                  res_data, res_tag, res_exception, unit_a, unit_b);
      end
   endtask

   task automatic test_directed();
      run_op(1'b0, 1'b1, 32'd100, 32'd7, 5'd3, 4, 1'b0, 1'b0, "div_100_7");
      run_op(1'b1, 1'b1, 32'd6, 32'd7, 5'd11, 5, 1'b0, 1'b0, "mult_and_div");
      run_op(1'b0, 1'b1, 32'd55, 32'd0, 5'd21, 4, 1'b0, 1'b0, "div_by_zero");
      run_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd7, 3, 1'b0, 1'b0, "mult_overflow");
      run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd31, 1, 1'b0, 1'b0, "mult_lat1");
   endtask

   task automatic test_timeout();
      run_op(1'b1, 1'b0, 32'd9, 32'd9, 5'd13, 4, 1'b1, 1'b0, "timeout_mult");
      run_op(1'b0, 1'b1, 32'd90, 32'd9, 5'd14, 4, 1'b1, 1'b0, "timeout_div");
   endtask

   task automatic test_flush();
      int stray;
      stray = 0;
      @(negedge clock);
      req_div = 1'b1; in_a = 32'd1000; in_b = 32'd10; in_tag = 5'd9;
      for (int cyc = 1; cyc <= 11; cyc++) begin
         @(negedge clock);
         if (res_valid) stray++;
         if (cyc == 11) begin
            tests_run++;
            if (busy !== 1'b0) begin
               tests_failed++;
               $display("FAIL flush_div busy after flush: got %0b want 0", busy);
            end
         end
         if (cyc == 1) req_div = 1'b0;
         if (cyc == 10) flush = 1'b1;
         if (cyc == 11) flush = 1'b0;
      end
      tests_run++;
      if (stray !== 0) begin
         tests_failed++;
         $display("FAIL flush_div res_valid: got %0d strobes want 0", stray);
      end
      // cycle 12: multiply issued right after the flushed divide
      run_op(1'b1, 1'b0, 32'd12, 32'd12, 5'd17, 6, 1'b0, 1'b1, "mult_after_flush");
   endtask

   task automatic test_flush_done();
      int stray;
      stray = 0;
      mlat = 3;
      @(negedge clock);
      req_mult = 1'b1; in_a = 32'd3; in_b = 32'd4; in_tag = 5'd5;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         @(negedge clock);
         if (cyc == 1) req_mult = 1'b0;
         if (cyc == 5) begin flush = 1'b1; #1; end
         if (res_valid) stray++;
         if (cyc == 5) flush = 1'b0;
         if (cyc == 6) begin
            tests_run++;
            if (busy !== 1'b0) begin
               tests_failed++;
               $display("FAIL flush_done busy: got %0b want 0", busy);
            end
         end
      end
      tests_run++;
      if (stray !== 0) begin
         tests_failed++;
         $display("FAIL flush_done res_valid: got %0d strobes want 0", stray);
      end
      // flush and request together in IDLE: request dropped
      req_mult = 1'b1; flush = 1'b1; in_a = 32'd2; in_b = 32'd2;
      @(negedge clock);
      req_mult = 1'b0; flush = 1'b0;
      tests_run++;
      if (busy !== 1'b0 || mult_start !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_req_idle: busy %0b mult_start %0b want 0 0", busy, mult_start);
      end
   endtask

   task automatic test_reset_mid();
      mlat = 20;
      @(negedge clock);
      req_mult = 1'b1; in_a = 32'd5; in_b = 32'd9; in_tag = 5'd2;
      @(negedge clock);
      req_mult = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      tests_run++;
      if (busy !== 1'b0 || unit_a !== 32'd0 || unit_b !== 32'd0 || res_data !== 32'd0 ||
          res_tag !== '0 || res_exception !== 1'b0 || res_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid: busy %0b unit_a %h unit_b %h res_data %h tag %0d exc %0b valid %0b want all 0",
                  busy, unit_a, unit_b, res_data, res_tag, res_exception, res_valid);
      end
      repeat (20) @(negedge clock);
   endtask

   task automatic test_back_to_back();
      run_op(1'b0, 1'b1, 32'd5000, 32'd3, 5'd1, 4, 1'b0, 1'b0, "b2b_div");
      run_op(1'b1, 1'b0, 32'd123, 32'd456, 5'd2, 7, 1'b0, 1'b1, "b2b_mult");
      run_op(1'b0, 1'b1, 32'hDEAD_BEEF, 32'd16, 5'd4, 4, 1'b0, 1'b1, "b2b_div2");
   endtask

   task automatic test_random();
      for (int i = 0; i < 10; i++) begin
         int kind;
         logic [31:0] a, b;
         kind = $urandom_range(0, 3);
         a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 70000));
         if (kind == 3) b = 32'd0;
         else b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 70000));
         run_op(kind == 0 || kind == 2, kind != 0, a, b, TAG_W'($urandom),
                $urandom_range(1, 30), 1'b0, 1'b0, "random_op");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_timeout();
      test_flush();
      test_flush_done();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequencer between the processor pipeline and the shared multiplier/divider datapaths. It accepts one multiply or divide request at a time and latches operands and destination tag. It pulses the selected unit's start, holds operands stable while the unit iterates, waits for the unit's ready, and returns a one-cycle result with the exception flag. While an operation is in flight it asserts `busy` so the pipeline stalls.

## Interface
- `TAG_W`, default 5: destination-register tag width.
- `TIMEOUT`, default 40: maximum cycles spent in a RUN state before a forced abort with exception; must be ≥ 34.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_mult` in 1: multiply request, sampled in IDLE only.
- `req_div` in 1: divide request, sampled in IDLE only.
- `in_a` in 32: multiplicand / dividend.
- `in_b` in 32: multiplier / divisor.
- `in_tag` in TAG_W: destination tag.
- `flush` in 1: abort any in-flight operation.
- `busy` out 1: state ≠ IDLE.
- `res_valid` out 1: one-cycle result strobe.
- `res_data` out 32: product or quotient.
- `res_tag` out TAG_W: tag of the completed operation.
- `res_exception` out 1: overflow, divide-by-zero or timeout.
- `unit_a` out 32: latched operand A to both units.
- `unit_b` out 32: latched operand B to both units.
- `mult_start` out 1: multiplier start pulse.
- `div_start` out 1: divider start pulse.
- `mult_ready` in 1: multiplier done.
- `mult_result` in 32: multiplier product.
- `mult_exception` in 1: multiplier overflow.
- `div_ready` in 1: divider done.
- `div_quotient` in 32: divider quotient.
- `div_exception` in 1: divider divide-by-zero.

## Operation
- States: IDLE, MULT_RUN, DIV_RUN, DONE. Reset → IDLE. All outputs and registers are 0 at reset.
- IDLE:
  - `req_mult` → MULT_RUN.
  - `req_div` only → DIV_RUN.
  - Both high → MULT_RUN; the divide request is dropped.
  - On either accepted request, latch `in_a`/`in_b` into `unit_a`/`unit_b`, latch `in_tag`, and clear the cycle counter.
- RUN states:
  - `mult_start`/`div_start` is high only in the first RUN cycle.
  - `unit_a`/`unit_b` are held constant for the whole operation, because the units read operands combinationally every iteration.
  - Ready is ignored in the first RUN cycle, since the unit counter is stale. From the second RUN cycle on, the selected unit's ready → DONE, capturing the result and exception into `res_data`/`res_exception`.
  - The cycle counter increments each RUN cycle. Reaching `TIMEOUT` → DONE with `res_data`=0 and `res_exception`=1.
- DONE: `res_valid`=1 for exactly one cycle with `res_tag`; then → IDLE.
- Requests while `busy` are ignored; the pipeline must hold them.
- `flush` in any state → IDLE next cycle. No `res_valid` is produced and no start is issued. `flush` in DONE suppresses that cycle's `res_valid`.
- `flush` together with a request in IDLE: `flush` wins and the request is dropped.
- `reset` mid-operation behaves like `flush` and also zeroes all outputs.
- `res_data`/`res_tag`/`res_exception` keep their values after DONE until the next capture.

## Timing
- Request sampled at the end of cycle 0 → `busy` and start high in cycle 1.
- Ready first sampled at the end of cycle 2.
- If ready is seen at the end of cycle k, `res_valid` is high in cycle k+1 and `busy` drops in cycle k+2.
- With the 32-iteration divider, ready rises in cycle 33, so `res_valid` is in cycle 34 and the next request is accepted in cycle 35.
- Latency = unit latency + 2 cycles. Back-to-back throughput is one operation per (latency + 1) cycles.
- No combinational path from `req_*` or `in_*` to any output; all outputs are registered or decoded from state.

## Configuration
- `MULTDIV_DIVZERO_EARLY_EN` defined:
  - A divide request with `in_b`==0 goes IDLE → DONE directly; `res_valid` is in cycle 1.
  - `res_data`=0, `res_exception`=1.
  - `div_start` is never asserted.
- Undefined: the divider runs the full iteration and `res_exception` is taken from `div_exception` at ready (`res_valid` in cycle 34).

## Test plan
- Reset, then idle 5 cycles → `busy`, `res_valid`, both starts = 0, even though `div_ready` is high after reset.
- `req_div`, `in_a`=100, `in_b`=7, `in_tag`=3:
  - `div_start` is high only in cycle 1.
  - `res_valid` is high only in cycle 34, with `res_data`=14, `res_tag`=3, `res_exception`=0.
  - `unit_a`/`unit_b` are unchanged in cycles 1–34.
- `req_mult` and `req_div` in the same cycle, `in_a`=6, `in_b`=7 → only `mult_start` fires, and the result is 42.
- Divide `in_b`=0:
  - Macro undefined → `res_valid` in cycle 34 with `res_exception`=1.
  - Macro defined → `res_valid` in cycle 1, `res_exception`=1, no `div_start`.
- `req_div`, `flush` in cycle 10, `req_mult` in cycle 12 → no result for the divide; the multiply completes normally with its own tag.
- Stub unit that never raises ready, `TIMEOUT`=40 → `res_valid` 41 cycles after request, `res_exception`=1, `res_data`=0, then `busy`=0.
